// File: rtl/intersection_scheduler.sv
// Intersection scheduler: round-robin arbitration of north-south and
// east-west vehicle demand plus a latched pedestrian request. Each phase
// runs for a timed duration, and an all-red clearance sits between any two
// grants.
module intersection_scheduler #(
   parameter int CNT_W     = 4,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 12,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int WALK_T    = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ns_req,
   input  logic       ew_req,
   input  logic       ped_req,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       ped_walk,
   output logic       ped_ack,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      ALL_RED   = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      PED_WALK  = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      GR_NS  = 2'd0,
      GR_EW  = 2'd1,
      GR_PED = 2'd2
   } grant_t;

   // Last timer value of each phase: a phase of duration D ends when timer == D-1
   localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] GMIN_END   = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] GMAX_END   = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_T - 1);

   state_t           state;
   state_t           state_next;
   grant_t           last_grant;
   logic [CNT_W-1:0] timer;
   logic             ped_pending;

   // Next-state selection, including the rotating-priority grant out of ALL_RED
   always_comb begin
      state_next = state;
      case (state)
         ALL_RED: begin
            if (timer >= ALLRED_END) begin
               case (last_grant)
                  GR_NS: begin
                     if (ew_req)           state_next = EW_GREEN;
                     else if (ped_pending) state_next = PED_WALK;
                     else if (ns_req)      state_next = NS_GREEN;
                  end
                  GR_EW: begin
                     if (ped_pending)      state_next = PED_WALK;
                     else if (ns_req)      state_next = NS_GREEN;
                     else if (ew_req)      state_next = EW_GREEN;
                  end
                  default: begin
                     if (ns_req)           state_next = NS_GREEN;
                     else if (ew_req)      state_next = EW_GREEN;
                     else if (ped_pending) state_next = PED_WALK;
                  end
               endcase
            end
         end
         NS_GREEN: begin
            if ((ew_req || ped_pending) &&
                ((timer >= GMIN_END && !ns_req) || timer >= GMAX_END))
               state_next = NS_YELLOW;
         end
         EW_GREEN: begin
            if ((ns_req || ped_pending) &&
                ((timer >= GMIN_END && !ew_req) || timer >= GMAX_END))
               state_next = EW_YELLOW;
         end
         NS_YELLOW, EW_YELLOW: begin
            if (timer >= YELLOW_END) state_next = ALL_RED;
         end
         PED_WALK: begin
            if (timer >= WALK_END) state_next = ALL_RED;
         end
         default: state_next = ALL_RED;
      endcase
   end

   // State register and phase timer; the timer restarts on every state change and saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ALL_RED;
         timer <= '0;
      end else begin
         state <= state_next;
         if (state_next != state)
            timer <= '0;
         else if (timer != '1)
            timer <= timer + CNT_W'(1);
      end
   end

   // Pedestrian latch; entering the walk phase takes priority over a new press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ped_pending <= 1'b0;
      else if (state_next == PED_WALK && state != PED_WALK)
         ped_pending <= 1'b0;
      else if (ped_req && state != PED_WALK)
         ped_pending <= 1'b1;
   end

   // Record the requester granted on each exit from ALL_RED
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= GR_PED;
      else if (state == ALL_RED) begin
         case (state_next)
            NS_GREEN: last_grant <= GR_NS;
            EW_GREEN: last_grant <= GR_EW;
            PED_WALK: last_grant <= GR_PED;
            default:  last_grant <= last_grant;
         endcase
      end
   end

   // Output decode; only one direction can ever show green or yellow
   always_comb begin
      ns_light = 3'b100;
      ew_light = 3'b100;
      ped_walk = 1'b0;
      ped_ack  = 1'b0;
      phase    = state;
      case (state)
         NS_GREEN:  ns_light = 3'b001;
         NS_YELLOW: ns_light = 3'b010;
         EW_GREEN:  ew_light = 3'b001;
         EW_YELLOW: ew_light = 3'b010;
         PED_WALK: begin
            ped_walk = 1'b1;
            ped_ack  = (timer == '0);
         end
         default: ;
      endcase
   end

endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 Parameter CNT_W, default 4: width of the phase timer.
REQ-002 Parameter GREEN_MIN, default 4: minimum green duration, in cycles.
REQ-003 Parameter GREEN_MAX, default 12: maximum green duration when another requester is waiting, in cycles.
REQ-004 Parameter YELLOW_T, default 3: yellow duration, in cycles.
REQ-005 Parameter ALLRED_T, default 1: all-red clearance duration, in cycles.
REQ-006 Parameter WALK_T, default 6: pedestrian walk duration, in cycles.
REQ-007 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 Port ns_req, input, 1 bit: north-south vehicle demand, level-sensitive.
REQ-010 Port ew_req, input, 1 bit: east-west vehicle demand, level-sensitive.
REQ-011 Port ped_req, input, 1 bit: pedestrian button; the block latches it internally.
REQ-012 Port ns_light, output, 3 bits: north-south signal, one-hot; 001 = green, 010 = yellow, 100 = red.
REQ-013 Port ew_light, output, 3 bits: east-west signal, same encoding as ns_light.
REQ-014 Port ped_walk, output, 1 bit: walk indication.
REQ-015 Port ped_ack, output, 1 bit: one-cycle pulse when a pedestrian request is granted.
REQ-016 Port phase, output, 3 bits: current state code (encoding listed in REQ-018).

Function
REQ-017 Parameter legality: 1 <= GREEN_MIN <= GREEN_MAX <= 2^CNT_W-1, and every other duration is between 1 and 2^CNT_W-1.
REQ-018 State machine states and codes: ALL_RED = 0, NS_GREEN = 1, NS_YELLOW = 2, EW_GREEN = 3, EW_YELLOW = 4, PED_WALK = 5; codes 6 and 7 recover to ALL_RED on the next clock.
REQ-019 Phase timer:
 - clears to 0 on every state change;
 - otherwise increments by 1 each cycle;
 - saturates at 2^CNT_W-1 (no wrap).
REQ-020 A phase of duration D ends on the cycle where timer == D-1, so the state is held for exactly D cycles.
REQ-021 ped_pending behaviour:
 - set by ped_req = 1 in any state except PED_WALK;
 - cleared in the cycle that PED_WALK is entered;
 - if set and clear occur in the same cycle, clear wins.
REQ-022 Round-robin grant order is NS -> EW -> PED -> NS; last_grant records the most recently granted requester.
REQ-023 ALL_RED behaviour:
 - once timer >= ALLRED_T-1, grant the first pending requester after last_grant (ns_req, ew_req or ped_pending);
 - with nothing pending, stay in ALL_RED and re-evaluate every cycle.
REQ-024 NS_GREEN / EW_GREEN exit condition, where "other pending" means a requester other than the current owner is pending:
 - go to the matching YELLOW when (timer >= GREEN_MIN-1, own request low, other pending) or (timer >= GREEN_MAX-1, other pending);
 - with no other pending, hold green indefinitely.
REQ-025 NS_YELLOW / EW_YELLOW last YELLOW_T cycles, then go to ALL_RED.
REQ-026 PED_WALK lasts WALK_T cycles, then goes to ALL_RED.
REQ-027 ped_ack is 1 only in the first cycle of PED_WALK.
REQ-028 Output decode from state:
 - ns_light is 001 in NS_GREEN, 010 in NS_YELLOW, 100 otherwise; ew_light follows the same rule for the EW states.
 - ped_walk = 1 only in PED_WALK.
 - Green or yellow is never shown on both ns_light and ew_light at once.
REQ-029 Requests arriving during YELLOW or ALL_RED are considered only at the next ALL_RED decision point.

Reset
REQ-030 rst_n = 0 immediately forces, from any state:
 - state = ALL_RED, timer = 0, ped_pending = 0, last_grant = PED (so NS has first priority);
 - ns_light = ew_light = 100, ped_walk = 0, ped_ack = 0, phase = 0.
REQ-031 After rst_n deasserts, the first ALL_RED phase lasts ALLRED_T cycles.

Verification
REQ-032 Reset released, all requests low -> lights stay 100/100, ped_walk = 0, phase = 0 for at least 50 cycles.
REQ-033 Only ns_req held from reset -> 1 cycle ALL_RED, then ns_light = 001 continuously for at least 40 cycles (no GREEN_MAX exit).
REQ-034 ns_req and ew_req both held -> NS green 12 cycles, yellow 3, all-red 1, then EW green 12 cycles, and the cycle repeats.
REQ-035 In NS green: ns_req drops at timer = 1 and ew_req rises -> NS green totals 4 cycles, then 010 for 3 cycles.
REQ-036 ns_req held, 1-cycle ped_req pulse at NS timer = 2 -> sequence:
 - NS green 12 cycles, yellow 3, all-red 1;
 - PED_WALK 6 cycles with ped_ack high only in its first cycle;
 - all-red 1, then NS green again.
REQ-037 rst_n pulsed low mid-NS_YELLOW with ped_pending = 1 -> lights become 100/100 without waiting for a clock edge; after release with no requests, no walk ever occurs.
